// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Purpose  : Shared defaults and compute-state encoding for the FFT frame
//             controller and its fill-side packer.
//  Revision : 1.0  initial release
// ============================================================================
package fft_pkg;

   localparam int c_def_sample_size  = 16;
   localparam int c_def_buffer_size  = 64;
   localparam int c_def_twiddle_size = 16;
   localparam int c_def_fft_latency  = 8;

   // Compute-side sequencing: wait for a frame, let the datapath settle, stream bins.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DRAIN  = 2'd2
   } compute_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fft_sample_packer
//  Purpose  : Deserialises the streaming sample input into one frame of
//             BUFFER_SIZE samples and holds it until the compute side takes it.
//  Revision : 1.0  initial release
// ============================================================================
module fft_sample_packer
   import fft_pkg::*;
#(
   parameter int SAMPLE_SIZE = c_def_sample_size,
   parameter int BUFFER_SIZE = c_def_buffer_size
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [SAMPLE_SIZE-1:0]            in_sample,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              launch,
   output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] frame,
   output logic                              full
);

   localparam int                 c_idx_w    = $clog2(BUFFER_SIZE);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(BUFFER_SIZE - 1);

   logic [BUFFER_SIZE-1:0][SAMPLE_SIZE-1:0] r_buf;
   logic [c_idx_w-1:0]                      r_wr_idx;
   logic                                    r_full;
   logic                                    w_accept;

   // A full buffer refuses input until the compute side has copied it out.
   assign in_ready = !r_full;
   assign w_accept = in_valid && !r_full;
   assign frame    = r_buf;
   assign full     = r_full;

   // Write accepted samples in order; the final slot marks the frame complete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf    <= '0;
         r_wr_idx <= '0;
         r_full   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_buf[r_wr_idx] <= in_sample;
            if (r_wr_idx == c_last_idx) begin
               r_wr_idx <= '0;
               r_full   <= 1'b1;
            end else begin
               r_wr_idx <= r_wr_idx + c_idx_w'(1);
            end
         end
         // launch only fires while full, so it never collides with an accept
         if (launch) begin
            r_full <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fft_frame_controller.sv
`default_nettype none
// ============================================================================
//  Module   : fft_frame_controller
//  Purpose  : Sequences a combinational FFT / partial-magnitude datapath:
//             launches a filled frame into a held input register, waits a
//             fixed settle time, captures the result and streams the bins.
//             Filling of the next frame overlaps settle/drain of this one.
//  Revision : 1.0  initial release
// ============================================================================
module fft_frame_controller
   import fft_pkg::*;
#(
   parameter int SAMPLE_SIZE = c_def_sample_size,
   parameter int BUFFER_SIZE = c_def_buffer_size,
   parameter int FFT_LATENCY = c_def_fft_latency
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [SAMPLE_SIZE-1:0]             in_sample,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] fft_frame,
   input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] fft_result,
   output logic [SAMPLE_SIZE-1:0]             out_bin,
   output logic [$clog2(BUFFER_SIZE)-1:0]     out_index,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               out_last,
   output logic                               busy
);

   localparam int                 c_idx_w       = $clog2(BUFFER_SIZE);
   localparam int                 c_cnt_w       = $clog2(FFT_LATENCY + 1);
   localparam logic [c_idx_w-1:0] c_last_idx    = c_idx_w'(BUFFER_SIZE - 1);
   localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(FFT_LATENCY - 1);

   compute_state_t                          r_state;
   compute_state_t                          w_state_nxt;
   logic [c_cnt_w-1:0]                      r_cnt;
   logic [c_cnt_w-1:0]                      w_cnt_nxt;
   logic [c_idx_w-1:0]                      r_out_index;
   logic [c_idx_w-1:0]                      w_out_index_nxt;
   logic                                    w_launch;
   logic                                    w_capture;
   logic                                    w_full;
   logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]      w_fill_frame;
   logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]      r_fft_frame;
   logic [BUFFER_SIZE-1:0][SAMPLE_SIZE-1:0] r_result;

   fft_sample_packer #(
      .SAMPLE_SIZE (SAMPLE_SIZE),
      .BUFFER_SIZE (BUFFER_SIZE)
   ) u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_sample (in_sample),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .launch    (w_launch),
      .frame     (w_fill_frame),
      .full      (w_full)
   );

   assign fft_frame = r_fft_frame;
   assign out_index = r_out_index;

   // Next-state and output decode; a frame only launches from IDLE, so a
   // pending full frame waits one cycle after DRAIN finishes.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_out_index_nxt = r_out_index;
      w_launch        = 1'b0;
      w_capture       = 1'b0;
      out_valid       = 1'b0;
      out_last        = 1'b0;
      busy            = 1'b1;
      out_bin         = r_result[r_out_index];
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (w_full) begin
               w_launch    = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (r_cnt == c_settle_last) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = DRAIN;
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_last  = (r_out_index == c_last_idx);
            if (out_ready) begin
               if (r_out_index == c_last_idx) begin
                  w_out_index_nxt = '0;
                  w_state_nxt     = IDLE;
               end else begin
                  w_out_index_nxt = r_out_index + c_idx_w'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Sequencer state: FSM state, settle counter and output bin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_out_index <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_out_index <= w_out_index_nxt;
      end
   end

   // Datapath holding registers: the FFT input stays frozen from one launch to
   // the next, and the result is sampled once the settle window has elapsed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fft_frame <= '0;
         r_result    <= '0;
      end else begin
         if (w_launch) begin
            r_fft_frame <= w_fill_frame;
         end
         if (w_capture) begin
            r_result <= fft_result;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_frame_controller
//  Purpose  : Self-checking bench for fft_frame_controller with a stub
//             datapath that reverses the element order of the frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_frame_controller;

   localparam int SS = 16;
   localparam int BS = 8;
   localparam int FL = 4;

   typedef struct packed {
      logic [2:0]    idx;
      logic [SS-1:0] bin;
      logic          last;
   } obs_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [SS-1:0]    in_sample;
   logic             in_valid;
   logic             in_ready;
   logic [BS*SS-1:0] fft_frame;
   logic [BS*SS-1:0] fft_result;
   logic [SS-1:0]    out_bin;
   logic [2:0]       out_index;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_hs_cyc = 0;

   logic [SS-1:0] feedq[$];
   obs_t          mon_q[$];

   fft_frame_controller #(
      .SAMPLE_SIZE (SS),
      .BUFFER_SIZE (BS),
      .FFT_LATENCY (FL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_sample  (in_sample),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .fft_frame  (fft_frame),
      .fft_result (fft_result),
      .out_bin    (out_bin),
      .out_index  (out_index),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stub datapath: result element k is frame element BS-1-k.
   always_comb begin
      fft_result = '0;
      for (int k = 0; k < BS; k++) fft_result[k*SS +: SS] = fft_frame[(BS-1-k)*SS +: SS];
   end

   // Inputs only change just after the rising edge, so a handshake seen here
   // is the one the next rising edge performs.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) mon_q.push_back({out_index, out_bin, out_last});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: frame element k of frame f is the (f*BS+k)-th accepted sample.
   function automatic logic [BS*SS-1:0] pack(input int base);
      logic [BS*SS-1:0] v = '0;
      for (int k = 0; k < BS; k++) v[k*SS +: SS] = feedq[base + k];
      return v;
   endfunction

   // Reference: bin j of a frame is the reversed frame element, in index order.
   function automatic obs_t expected_obs(input int base, input int n);
      obs_t e;
      int   f = n / BS;
      int   j = n % BS;
      e.idx  = 3'(j);
      e.bin  = feedq[base + f*BS + (BS-1-j)];
      e.last = (j == BS-1);
      return e;
   endfunction

   task automatic feed(input int pct, input int base, input int cnt);
      int   n = 0;
      int   guard = 0;
      logic hs;
      while (n < cnt) begin
         in_valid  = ($urandom_range(99) < pct);
         in_sample = in_valid ? feedq[base + n] : SS'($urandom);
         hs        = in_valid && in_ready;
         step();
         if (hs) begin
            n++;
            last_hs_cyc = cyc;
         end
         guard++;
         if (guard > 600) begin
            checks++; errors++;
            $display("FAIL feed_timeout accepted=%0d required=%0d", n, cnt);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_bins(input int n);
      int g = 0;
      while (mon_q.size() < n && g < 300) begin
         step();
         g++;
      end
      if (mon_q.size() < n) begin
         checks++; errors++;
         $display("FAIL bin_timeout got=%0d required=%0d", mon_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
      repeat (3) step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
      checks++; if (fft_frame !== '0) begin errors++; $display("FAIL rst_fft_frame got=%h want=0", fft_frame); end
      checks++; if (out_index !== 3'd0 || out_last !== 1'b0 || out_bin !== '0) begin
         errors++; $display("FAIL rst_out got idx=%0d last=%b bin=%h want 0/0/0", out_index, out_last, out_bin);
      end
      @(negedge clk); rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_frame();
      int t_frame = -1;
      int t_valid = -1;
      obs_t e;
      feedq.delete(); mon_q.delete();
      for (int k = 1; k <= BS; k++) feedq.push_back(SS'(k));
      out_ready = 1'b1;
      feed(100, 0, BS);
      for (int i = 0; i < 20 && t_valid < 0; i++) begin
         step();
         if (t_frame < 0 && fft_frame === pack(0)) t_frame = cyc;
         if (out_valid === 1'b1) t_valid = cyc;
      end
      checks++; if (t_frame - last_hs_cyc != 1) begin
         errors++; $display("FAIL single_launch_delay got=%0d want=1", t_frame - last_hs_cyc);
      end
      checks++; if (t_valid - t_frame != FL) begin
         errors++; $display("FAIL single_settle got=%0d want=%0d", t_valid - t_frame, FL);
      end
      wait_bins(BS);
      for (int n = 0; n < BS; n++) begin
         e = expected_obs(0, n);
         checks++;
         if (n >= mon_q.size() || mon_q[n] !== e) begin
            errors++; $display("FAIL single_bin%0d got=%h want=%h", n, (n < mon_q.size()) ? mon_q[n] : obs_t'(0), e);
         end
      end
      checks++; if (busy !== 1'b0 || fft_frame !== pack(0)) begin
         errors++; $display("FAIL single_after got busy=%b frame=%h want busy=0 frame=%h", busy, fft_frame, pack(0));
      end
   endtask

   task automatic test_backpressure();
      obs_t e;
      feedq.delete(); mon_q.delete();
      for (int k = 0; k < 2*BS; k++) feedq.push_back(SS'($urandom));
      out_ready = 1'b0;
      feed(100, 0, BS);
      feed(100, BS, BS);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
      checks++; if (out_valid !== 1'b1 || out_bin !== feedq[BS-1] || out_index !== 3'd0) begin
         errors++; $display("FAIL bp_hold got v=%b bin=%h idx=%0d want v=1 bin=%h idx=0", out_valid, out_bin, out_index, feedq[BS-1]);
      end
      repeat (3) step();
      checks++; if (out_bin !== feedq[BS-1] || out_last !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_hold_late got bin=%h last=%b rdy=%b want bin=%h last=0 rdy=0", out_bin, out_last, in_ready, feedq[BS-1]);
      end
      out_ready = 1'b1;
      wait_bins(BS);
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_idle got busy=%b v=%b rdy=%b want 0/0/0", busy, out_valid, in_ready);
      end
      step();
      checks++; if (busy !== 1'b1 || fft_frame !== pack(BS) || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_relaunch got busy=%b rdy=%b frame=%h want busy=1 rdy=1 frame=%h", busy, in_ready, fft_frame, pack(BS));
      end
      wait_bins(2*BS);
      for (int n = 0; n < 2*BS; n++) begin
         e = expected_obs(0, n);
         checks++;
         if (n >= mon_q.size() || mon_q[n] !== e) begin
            errors++; $display("FAIL bp_bin%0d got=%h want=%h", n, (n < mon_q.size()) ? mon_q[n] : obs_t'(0), e);
         end
      end
   endtask

   task automatic test_stall();
      obs_t          e;
      logic          pv, pr, plast;
      logic [SS-1:0] pbin;
      logic [2:0]    pidx;
      feedq.delete(); mon_q.delete();
      for (int k = 0; k < BS; k++) feedq.push_back(SS'($urandom));
      out_ready = 1'b0;
      feed(100, 0, BS);
      for (int i = 0; i < 80 && mon_q.size() < BS; i++) begin
         out_ready = (i % 2 == 0);
         pv = out_valid; pr = out_ready; pbin = out_bin; pidx = out_index; plast = out_last;
         step();
         if (pv && !pr) begin
            checks++;
            if (out_bin !== pbin || out_index !== pidx || out_last !== plast || out_valid !== 1'b1) begin
               errors++; $display("FAIL stall_hold got bin=%h idx=%0d last=%b want bin=%h idx=%0d last=%b", out_bin, out_index, out_last, pbin, pidx, plast);
            end
         end
      end
      out_ready = 1'b1;
      repeat (4) step();
      checks++; if (mon_q.size() != BS) begin
         errors++; $display("FAIL stall_count got=%0d want=%0d", mon_q.size(), BS);
      end
      for (int n = 0; n < BS; n++) begin
         e = expected_obs(0, n);
         checks++;
         if (n >= mon_q.size() || mon_q[n] !== e) begin
            errors++; $display("FAIL stall_bin%0d got=%h want=%h", n, (n < mon_q.size()) ? mon_q[n] : obs_t'(0), e);
         end
      end
   endtask

   task automatic test_async_reset();
      obs_t e;
      int   g = 0;
      feedq.delete(); mon_q.delete();
      for (int k = 0; k < BS + 3; k++) feedq.push_back(SS'($urandom));
      out_ready = 1'b1;
      feed(100, 0, BS);
      feed(100, BS, 3);
      while (!(out_valid === 1'b1 && out_index === 3'd3) && g < 60) begin
         step();
         g++;
      end
      checks++; if (out_index !== 3'd3) begin errors++; $display("FAIL ar_reach_idx3 got=%0d want=3", out_index); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_index !== 3'd0 || out_last !== 1'b0 || out_bin !== '0) begin
         errors++; $display("FAIL ar_out got v=%b idx=%0d last=%b bin=%h want 0", out_valid, out_index, out_last, out_bin);
      end
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || fft_frame !== '0) begin
         errors++; $display("FAIL ar_state got busy=%b rdy=%b frame=%h want 0/1/0", busy, in_ready, fft_frame);
      end
      @(negedge clk); rst_n = 1'b1;
      step();
      feedq.delete(); mon_q.delete();
      for (int k = 0; k < BS; k++) feedq.push_back(SS'($urandom));
      feed(100, 0, BS);
      wait_bins(BS);
      repeat (4) step();
      checks++; if (mon_q.size() != BS) begin
         errors++; $display("FAIL ar_count got=%0d want=%0d", mon_q.size(), BS);
      end
      for (int n = 0; n < BS; n++) begin
         e = expected_obs(0, n);
         checks++;
         if (n >= mon_q.size() || mon_q[n] !== e) begin
            errors++; $display("FAIL ar_bin%0d got=%h want=%h", n, (n < mon_q.size()) ? mon_q[n] : obs_t'(0), e);
         end
      end
   endtask

   task automatic test_sparse();
      obs_t e;
      feedq.delete(); mon_q.delete();
      for (int k = 0; k < 3*BS; k++) feedq.push_back(SS'($urandom));
      out_ready = 1'b1;
      feed(25, 0, 3*BS);
      wait_bins(3*BS);
      for (int n = 0; n < 3*BS; n++) begin
         e = expected_obs(0, n);
         checks++;
         if (n >= mon_q.size() || mon_q[n] !== e) begin
            errors++; $display("FAIL sparse_bin%0d got=%h want=%h", n, (n < mon_q.size()) ? mon_q[n] : obs_t'(0), e);
         end
      end
      checks++; if (fft_frame !== pack(2*BS)) begin
         errors++; $display("FAIL sparse_frame got=%h want=%h", fft_frame, pack(2*BS));
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_stall();
      test_async_reset();
      test_sparse();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
